// File: rtl/bus_pkg.sv
// Shared types for the CPU-to-AXI4-Lite bridge.
// States, request/size/response codes, owner ids.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  localparam logic [1:0] REQ_READ  = 2'b00;
  localparam logic [1:0] REQ_WRITE = 2'b01;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_FETCH = 3'b100;

  typedef struct packed {
    logic        vld;
    logic        owner;
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
  } req_t;

endpackage

// File: rtl/cpu_axi_lite_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and address offset.
// Lanes past the 8-byte boundary are dropped.
module wstrb_gen
  import bus_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] off,
  output logic [7:0] strb
);

  logic [7:0] base;

  // Contiguous lane mask for the access size
  always_comb begin
    base = 8'h01;
    unique case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0F;
      SIZE_D:  base = 8'hFF;
      default: base = 8'h01;
    endcase
  end

  assign strb = base << off;

endmodule

// File: rtl/cpu_axi_lite_bridge.sv
// Fetch + data ports onto one AXI4-Lite master.
// One transaction in flight, data port wins.
module cpu_axi_lite_bridge
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_valid,
  input  logic [63:0]         if_addr,
  input  logic [1:0]          if_size,
  output logic                if_ready,
  output logic [1:0]          if_resp,
  output logic [DATA_W-1:0]   if_data_read,

  input  logic                mem_valid,
  input  logic [63:0]         mem_addr,
  input  logic [1:0]          mem_size,
  input  logic [1:0]          mem_req,
  input  logic [DATA_W-1:0]   mem_data_write,
  output logic                mem_ready,
  output logic [1:0]          mem_resp,
  output logic [DATA_W-1:0]   mem_data_read,

  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,

  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,

  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,

  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,

  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_t     state;
  logic       owner;
  req_t       gnt;
  logic [7:0] strb_nxt;
  logic       unused_hi;

  assign unused_hi = ^(gnt.addr >> ADDR_W);

  // Fixed-priority pick of the pending request
  always_comb begin
    gnt = '0;
    priority case (1'b1)
      mem_valid: begin
        gnt.vld   = 1'b1;
        gnt.owner = OWN_MEM;
        gnt.wr    = (mem_req == REQ_WRITE);
        gnt.addr  = mem_addr;
        gnt.size  = mem_size;
      end
      if_valid: begin
        gnt.vld   = 1'b1;
        gnt.owner = OWN_IF;
        gnt.wr    = 1'b0;
        gnt.addr  = if_addr;
        gnt.size  = if_size;
      end
      default: gnt = '0;
    endcase
  end

  wstrb_gen u_strb (
    .size (gnt.size),
    .off  (gnt.addr[2:0]),
    .strb (strb_nxt)
  );

  // Bus sequencer with registered AXI and port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      araddr        <= '0;
      arprot        <= '0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      awaddr        <= '0;
      awvalid       <= 1'b0;
      wdata         <= '0;
      wstrb         <= '0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      if_ready      <= 1'b0;
      if_resp       <= '0;
      if_data_read  <= '0;
      mem_ready     <= 1'b0;
      mem_resp      <= '0;
      mem_data_read <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt.vld) begin
            owner <= gnt.owner;
            if (gnt.wr) begin
              awaddr  <= gnt.addr[ADDR_W-1:0];
              wdata   <= mem_data_write;
              wstrb   <= strb_nxt;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              araddr  <= gnt.addr[ADDR_W-1:0];
              arprot  <= gnt.owner ? PROT_DATA
                                   : PROT_FETCH;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= DONE;
            if (owner == OWN_MEM) begin
              mem_ready     <= 1'b1;
              mem_resp      <= rresp;
              mem_data_read <= rdata;
            end else begin
              if_ready     <= 1'b1;
              if_resp      <= rresp;
              if_data_read <= rdata;
            end
          end
        end
        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((awready || !awvalid) &&
              (wready  || !wvalid)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready        <= 1'b0;
            mem_ready     <= 1'b1;
            mem_resp      <= bresp;
            mem_data_read <= '0;
            state         <= DONE;
          end
        end
        DONE: begin
          if_ready      <= 1'b0;
          if_resp       <= '0;
          if_data_read  <= '0;
          mem_ready     <= 1'b0;
          mem_resp      <= '0;
          mem_data_read <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_lite_bridge.sv
// Directed bench for cpu_axi_lite_bridge.
// Slave BFM + ordered transaction model + per-cycle checker.
module tb_cpu_axi_lite_bridge;
  import bus_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } bus_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } cmp_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          dly;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [63:0] if_addr = '0;
  logic [1:0]  if_size = '0;
  logic        if_ready;
  logic [1:0]  if_resp;
  logic [63:0] if_data_read;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [1:0]  mem_size = '0;
  logic [1:0]  mem_req = '0;
  logic [63:0] mem_data_write = '0;
  logic        mem_ready;
  logic [1:0]  mem_resp;
  logic [63:0] mem_data_read;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bus_t exp_bus[$];
  cmp_t exp_if[$];
  cmp_t exp_mem[$];
  rsp_t r_q[$];
  rsp_t b_q[$];

  int ar_dly = 0;
  int aw_dly = 0;
  int w_dly  = 0;

  cpu_axi_lite_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_size        (if_size),
    .if_ready       (if_ready),
    .if_resp        (if_resp),
    .if_data_read   (if_data_read),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_size       (mem_size),
    .mem_req        (mem_req),
    .mem_data_write (mem_data_write),
    .mem_ready      (mem_ready),
    .mem_resp       (mem_resp),
    .mem_data_read  (mem_data_read),
    .araddr         (araddr),
    .arprot         (arprot),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .awaddr         (awaddr),
    .awvalid        (awvalid),
    .awready        (awready),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wvalid         (wvalid),
    .wready         (wready),
    .bresp          (bresp),
    .bvalid         (bvalid),
    .bready         (bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got none want event", nm);
  endtask

  function automatic logic [7:0] strb_of(
    input logic [1:0] sz, input logic [2:0] off);
    int nbytes;
    int mask;
    nbytes = 1 << sz;
    mask   = ((1 << nbytes) - 1) << off;
    return 8'(mask & 255);
  endfunction

  // Model: one request -> expected bus beat,
  // expected completion and slave response.
  function automatic void model_req(
    input bit is_mem, input bit wr,
    input logic [63:0] a, input logic [1:0] sz,
    input logic [63:0] wd, input logic [63:0] rd,
    input logic [1:0] rsp, input int dly);
    bus_t b;
    cmp_t c;
    rsp_t s;
    b.wr    = wr;
    b.addr  = a[31:0];
    b.prot  = is_mem ? 3'b000 : 3'b100;
    b.wdata = wd;
    b.strb  = wr ? strb_of(sz, a[2:0]) : 8'h00;
    exp_bus.push_back(b);
    c.data = wr ? 64'h0 : rd;
    c.resp = rsp;
    if (is_mem) exp_mem.push_back(c);
    else        exp_if.push_back(c);
    s.data = rd;
    s.resp = rsp;
    s.dly  = dly;
    if (wr) b_q.push_back(s);
    else    r_q.push_back(s);
  endfunction

  rsp_t cur_r;
  rsp_t cur_b;
  int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int   r_cnt = 0, b_cnt = 0;
  bit   r_act = 0, b_act = 0;

  // Slave BFM, drives mid-cycle
  always @(negedge clk) begin
    #2;
    if (!arvalid) begin arready = 0; ar_cnt = 0; end
    else if (!arready) begin
      if (ar_cnt >= ar_dly) arready = 1;
      else ar_cnt++;
    end
    if (!awvalid) begin awready = 0; aw_cnt = 0; end
    else if (!awready) begin
      if (aw_cnt >= aw_dly) awready = 1;
      else aw_cnt++;
    end
    if (!wvalid) begin wready = 0; w_cnt = 0; end
    else if (!wready) begin
      if (w_cnt >= w_dly) wready = 1;
      else w_cnt++;
    end
    if (!rready) begin rvalid = 0; r_act = 0; end
    else if (!rvalid) begin
      if (!r_act) begin
        cur_r = '{64'h0, 2'b00, 0};
        if (r_q.size() > 0) cur_r = r_q.pop_front();
        r_cnt = 0;
        r_act = 1;
      end
      if (r_cnt >= cur_r.dly) begin
        rvalid = 1;
        rdata  = cur_r.data;
        rresp  = cur_r.resp;
      end else r_cnt++;
    end
    if (!bready) begin bvalid = 0; b_act = 0; end
    else if (!bvalid) begin
      if (!b_act) begin
        cur_b = '{64'h0, 2'b00, 0};
        if (b_q.size() > 0) cur_b = b_q.pop_front();
        b_cnt = 0;
        b_act = 1;
      end
      if (b_cnt >= cur_b.dly) begin
        bvalid = 1;
        bresp  = cur_b.resp;
      end else b_cnt++;
    end
  end

  logic        p_arv = 0, p_awv = 0, p_wv = 0;
  logic        p_rr = 0, p_br = 0;
  logic [31:0] p_araddr = 0, p_awaddr = 0;
  logic [2:0]  p_arprot = 0;
  logic [63:0] p_wdata = 0;
  logic [7:0]  p_wstrb = 0;
  bit          aw_hit = 0, w_hit = 0;
  int          last_ar_cyc = 0, last_aw_cyc = 0;
  int          last_rr_cyc = 0, last_br_cyc = 0;
  logic [63:0] last_if_data = 0;
  logic [1:0]  last_mem_resp = 0;
  logic [7:0]  last_wstrb = 0;

  // Per-cycle compare against the model queues
  always @(negedge clk) begin
    if (rst) begin
      p_arv = 0; p_awv = 0; p_wv = 0;
      p_rr = 0; p_br = 0;
      aw_hit = 0; w_hit = 0;
    end else begin
      if (p_arv && !arready)
        check("ar hold", {arvalid, araddr, arprot},
              {1'b1, p_araddr, p_arprot});
      else if (arvalid) begin
        last_ar_cyc = cyc;
        if (exp_bus.size() == 0 || exp_bus[0].wr)
          fail("ar unexpected");
        else begin
          check("araddr", araddr, exp_bus[0].addr);
          check("arprot", arprot, exp_bus[0].prot);
          void'(exp_bus.pop_front());
        end
      end
      if (p_awv && !awready)
        check("aw hold", {awvalid, awaddr},
              {1'b1, p_awaddr});
      else if (awvalid) begin
        last_aw_cyc = cyc;
        if (exp_bus.size() == 0 || !exp_bus[0].wr)
          fail("aw unexpected");
        else begin
          check("awaddr", awaddr, exp_bus[0].addr);
          aw_hit = 1;
        end
      end
      if (p_wv && !wready)
        check("w hold", {wvalid, wstrb, wdata},
              {1'b1, p_wstrb, p_wdata});
      else if (wvalid) begin
        last_wstrb = wstrb;
        if (exp_bus.size() == 0 || !exp_bus[0].wr)
          fail("w unexpected");
        else begin
          check("wdata", wdata, exp_bus[0].wdata);
          check("wstrb", wstrb, exp_bus[0].strb);
          w_hit = 1;
        end
      end
      if (aw_hit && w_hit) begin
        void'(exp_bus.pop_front());
        aw_hit = 0;
        w_hit  = 0;
      end
      if (rready && !p_rr) last_rr_cyc = cyc;
      if (bready && !p_br) last_br_cyc = cyc;
      if (if_ready && mem_ready)
        check("both ready", 2'b11, 2'b01);
      if (if_ready) begin
        last_if_data = if_data_read;
        if (exp_if.size() == 0) fail("if_ready unexpected");
        else begin
          check("if data", if_data_read, exp_if[0].data);
          check("if resp", if_resp, exp_if[0].resp);
          void'(exp_if.pop_front());
        end
      end
      if (mem_ready) begin
        last_mem_resp = mem_resp;
        if (exp_mem.size() == 0) fail("mem_ready unexpected");
        else begin
          check("mem data", mem_data_read, exp_mem[0].data);
          check("mem resp", mem_resp, exp_mem[0].resp);
          void'(exp_mem.pop_front());
        end
      end
      p_arv = arvalid; p_araddr = araddr; p_arprot = arprot;
      p_awv = awvalid; p_awaddr = awaddr;
      p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
      p_rr = rready; p_br = bready;
    end
  end

  task automatic do_fetch(input logic [63:0] a,
                          input logic [1:0] sz,
                          input bit drop,
                          output int c0, output int rc);
    @(negedge clk);
    if_addr = a; if_size = sz; if_valid = 1;
    c0 = cyc; rc = -1;
    if (drop) begin @(negedge clk); if_valid = 0; end
    for (int i = 0; i < 100 && rc < 0; i++) begin
      @(negedge clk);
      if (if_ready) begin rc = cyc; if_valid = 0; end
    end
    if (rc < 0) begin fail("fetch timeout"); if_valid = 0; end
  endtask

  task automatic do_mem(input logic [63:0] a,
                        input logic [1:0] sz,
                        input logic [1:0] rq,
                        input logic [63:0] wd,
                        output int c0, output int rc);
    @(negedge clk);
    mem_addr = a; mem_size = sz; mem_req = rq;
    mem_data_write = wd; mem_valid = 1;
    c0 = cyc; rc = -1;
    for (int i = 0; i < 100 && rc < 0; i++) begin
      @(negedge clk);
      if (mem_ready) begin rc = cyc; mem_valid = 0; end
    end
    if (rc < 0) begin fail("mem timeout"); mem_valid = 0; end
  endtask

  int c0, rc, c1, rc1;
  bit seen;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst ctrl", {arvalid, rready, awvalid, wvalid,
          bready, if_ready, mem_ready, if_resp, mem_resp}, 0);
    check("rst rdata", if_data_read | mem_data_read, 0);
    check("rst addr", {araddr, awaddr}, 0);
    check("rst wdata", wdata, 0);
    check("rst strb prot", {wstrb, arprot}, 0);
    @(negedge clk);
    rst = 0;

    // Fetch dword, zero wait
    model_req(0, 0, 64'h8000_0000, SIZE_D, 0,
              64'h1122334455667788, RESP_OKAY, 0);
    do_fetch(64'h8000_0000, SIZE_D, 0, c0, rc);
    #1;
    check("t1 ar lat", 64'(last_ar_cyc), 64'(c0 + 1));
    check("t1 rready lat", 64'(last_rr_cyc), 64'(c0 + 2));
    check("t1 ready lat", 64'(rc), 64'(c0 + 3));
    check("t1 data lit", last_if_data, 64'h1122334455667788);

    // Simultaneous: data read wins
    model_req(1, 0, 64'h2000_0008, SIZE_D, 0,
              64'hA5A5_0000_1234_5678, RESP_OKAY, 0);
    model_req(0, 0, 64'h8000_0008, SIZE_W, 0,
              64'h0000_0000_DEAD_BEEF, RESP_OKAY, 0);
    fork
      do_mem(64'h2000_0008, SIZE_D, REQ_READ, 0, c0, rc);
      do_fetch(64'h8000_0008, SIZE_W, 0, c1, rc1);
    join
    #1;
    check("t2 fetch ar after mem", 64'(last_ar_cyc), 64'(rc + 2));
    check("t2 spacing", 64'(rc1 - rc), 64'd4);

    // Half write, AW 3 cycles behind W
    aw_dly = 3; w_dly = 0;
    model_req(1, 1, 64'h8000_0006, SIZE_H,
              64'hBEEF_0000_0000_0000, 0, RESP_OKAY, 1);
    do_mem(64'h8000_0006, SIZE_H, REQ_WRITE,
           64'hBEEF_0000_0000_0000, c0, rc);
    #1;
    check("t3 wstrb lit", last_wstrb, 8'hC0);
    aw_dly = 0;

    // Zero-wait word write latency
    model_req(1, 1, 64'h1000_0004, SIZE_W,
              64'h0123_4567_0000_0000, 0, RESP_OKAY, 0);
    do_mem(64'h1000_0004, SIZE_W, REQ_WRITE,
           64'h0123_4567_0000_0000, c0, rc);
    #1;
    check("t4 aw lat", 64'(last_aw_cyc), 64'(c0 + 1));
    check("t4 bready lat", 64'(last_br_cyc), 64'(c0 + 2));
    check("t4 ready lat", 64'(rc), 64'(c0 + 3));
    check("t4 wstrb lit", last_wstrb, 8'hF0);

    // Misaligned dword write, truncated strobe, DECERR
    w_dly = 2;
    model_req(1, 1, 64'h1000_0005, SIZE_D,
              64'hFFEE_DDCC_BBAA_9988, 0, RESP_DECERR, 0);
    do_mem(64'h1000_0005, SIZE_D, REQ_WRITE,
           64'hFFEE_DDCC_BBAA_9988, c0, rc);
    #1;
    check("t5 wstrb lit", last_wstrb, 8'hE0);
    check("t5 resp lit", last_mem_resp, RESP_DECERR);
    w_dly = 0;

    // SLVERR read after stalls; req code 11 reads
    ar_dly = 2;
    model_req(1, 0, 64'h3000_0010, SIZE_W, 0,
              64'h0000_0000_0BAD_F00D, RESP_SLVERR, 5);
    do_mem(64'h3000_0010, SIZE_W, 2'b11, 64'h55, c0, rc);
    #1;
    check("t6 resp lit", last_mem_resp, 2'b10);
    check("t6 ready lat", 64'(rc), 64'(c0 + 10));
    ar_dly = 0;

    // Reset while waiting in RD_DATA
    model_req(0, 0, 64'h8000_0040, SIZE_D, 0,
              64'h77, RESP_OKAY, 20);
    @(negedge clk);
    if_addr = 64'h8000_0040; if_size = SIZE_D; if_valid = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rready) seen = 1;
    end
    if (!seen) fail("t7 rready timeout");
    #3 rst = 1;
    #1;
    check("t7 rst ctrl", {arvalid, rready, awvalid, wvalid,
          bready, if_ready, mem_ready, if_resp, mem_resp}, 0);
    check("t7 rst rdata", if_data_read | mem_data_read, 0);
    check("t7 rst addr", {araddr, awaddr}, 0);
    if_valid = 0;
    exp_if.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    model_req(0, 0, 64'h8000_0080, SIZE_D, 0,
              64'hCAFE_F00D_0000_0001, RESP_OKAY, 0);
    do_fetch(64'h8000_0080, SIZE_D, 0, c0, rc);
    #1;
    check("t7 post data", last_if_data, 64'hCAFE_F00D_0000_0001);
    check("t7 post lat", 64'(rc), 64'(c0 + 3));

    // Drop if_valid right after grant
    model_req(0, 0, 64'h8000_0100, SIZE_W, 0,
              64'h0000_0000_1357_9BDF, RESP_OKAY, 1);
    do_fetch(64'h8000_0100, SIZE_W, 1, c0, rc);
    #1;
    check("t8 ready lat", 64'(rc), 64'(c0 + 4));
    repeat (6) @(negedge clk);
    #1;
    check("t8 idle", {arvalid, rready, awvalid, wvalid,
          bready, if_ready, mem_ready}, 0);

    check("queues drained",
          64'(exp_bus.size() + exp_if.size() + exp_mem.size()),
          0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
